// File: rtl/bias_add_sequencer.sv
// Bias-add sequencer: saturating per-lane add of the current group's bias to each accepted beat, walking bias groups across a layer pass.
// One-cycle latency; acc_ready drops while a registered beat is held by out_ready=0, so the pipe never overwrites or drops data.
module bias_add_sequencer #(
    parameter int N_adder_tree  = 16,
    parameter int W             = 18,
    parameter int N_GROUPS      = 4,
    parameter int PIX_PER_GROUP = 196,
    localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
    localparam int PW = (PIX_PER_GROUP > 1) ? $clog2(PIX_PER_GROUP) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [GW-1:0]             grp_sel,
    input  logic [N_adder_tree*W-1:0] bias_in,
    input  logic [N_adder_tree*W-1:0] acc_in,
    input  logic                      acc_valid,
    output logic                      acc_ready,
    output logic [N_adder_tree*W-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [PW-1:0] LAST_PIX = PW'(PIX_PER_GROUP - 1);
    localparam logic [GW-1:0] LAST_GRP = GW'(N_GROUPS - 1);

    state_t                    state, state_nxt;
    logic [PW-1:0]             pix;
    logic [N_adder_tree*W-1:0] sum_sat;
    logic                      accept;
    logic                      last_beat;

    assign accept    = acc_valid && acc_ready;
    assign last_beat = (pix == LAST_PIX) && (grp_sel == LAST_GRP);

    // Widen by one bit so overflow shows up as a mismatch of the top two sum bits.
    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        logic signed [W:0] s;
        assign s = {acc_in[W*(i+1)-1], acc_in[W*i +: W]}
                 + {bias_in[W*(i+1)-1], bias_in[W*i +: W]};
        assign sum_sat[W*i +: W] = (s[W] != s[W-1])
                                 ? (s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                                 : s[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && last_beat) state_nxt = S_DRAIN;
            S_DRAIN: if (!out_valid || out_ready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        acc_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_RUN: begin
                acc_ready = !out_valid || out_ready;
                busy      = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_sel   <= '0;
            pix       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                grp_sel <= '0;
                pix     <= '0;
            end else if (accept) begin
                if (pix == LAST_PIX) begin
                    pix <= '0;
                    // Hold on the last group so grp_sel stays in range until the next start.
                    if (grp_sel != LAST_GRP) grp_sel <= grp_sel + 1'b1;
                end else begin
                    pix <= pix + 1'b1;
                end
            end
            if (accept) begin
                out_data  <= sum_sat;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bias_add_sequencer.sv
// Directed bench for bias_add_sequencer with a 2-group, 3-pixel pass; expected lane values are hand-computed.
module tb_bias_add_sequencer;

    localparam int N = 16;
    localparam int W = 18;

    logic          clk = 1'b0;
    logic          rst, start, acc_valid, out_ready;
    logic [0:0]    grp_sel;
    logic [N*W-1:0] bias_in, acc_in, out_data, b0, b1;
    logic          acc_ready, out_valid, busy, done;

    int checks = 0;
    int errors = 0;

    bias_add_sequencer #(
        .N_adder_tree(N), .W(W), .N_GROUPS(2), .PIX_PER_GROUP(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .grp_sel(grp_sel),
        .bias_in(bias_in), .acc_in(acc_in), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // External bias bank mux
    always_comb bias_in = (grp_sel == 1'b0) ? b0 : b1;

    function automatic logic signed [W-1:0] lane(input logic [N*W-1:0] v, input int i);
        return v[W*i +: W];
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acc(input int a0, input int a1, input int a2);
        acc_in = '0;
        acc_in[W*0 +: W] = W'(a0);
        acc_in[W*1 +: W] = W'(a1);
        acc_in[W*2 +: W] = W'(a2);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            b0[W*i +: W] = W'(i * 10);
            b1[W*i +: W] = W'(-i);
        end
        b0[W*0 +: W] = W'(3958);
        b0[W*1 +: W] = W'(-750);
        b0[W*2 +: W] = W'(4);
        b1[W*0 +: W] = W'(-1000);
        b1[W*1 +: W] = W'(500);
        b1[W*2 +: W] = W'(7);

        // Reset, with start asserted alongside: reset wins
        rst = 1'b1; start = 1'b1; acc_valid = 1'b0; out_ready = 1'b1; set_acc(0, 0, 0);
        tick();
        start = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", lane(out_data, 0), 0);
        chk("rst_grp_sel", grp_sel, 0);
        chk("rst_done", done, 0);

        // Idle: valid data but no start
        rst = 1'b0; acc_valid = 1'b1; set_acc(100, 200, -4);
        tick();
        chk("idle_acc_ready", acc_ready, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_grp_sel", grp_sel, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_grp_sel", grp_sel, 0);
        chk("start_out_valid", out_valid, 0);
        #1 chk("run_acc_ready", acc_ready, 1);

        // Beat 0 (grp 0): basic add
        tick();
        chk("b0_out_valid", out_valid, 1);
        chk("b0_lane0", lane(out_data, 0), 4058);
        chk("b0_lane1", lane(out_data, 1), -550);
        chk("b0_lane2", lane(out_data, 2), 0);
        chk("b0_lane5", lane(out_data, 5), 50);
        set_acc(131000, -131000, -4);
        #1 chk("b0_acc_ready", acc_ready, 1);

        // Beat 1 (grp 0): saturation, accepted back-to-back
        tick();
        chk("b1_out_valid", out_valid, 1);
        chk("b1_lane0_sat_hi", lane(out_data, 0), 131071);
        chk("b1_lane1_sat_lo", lane(out_data, 1), -131072);
        chk("b1_lane2", lane(out_data, 2), 0);

        // Backpressure: beat 1 held, beat 2 waits
        out_ready = 1'b0; set_acc(1, 2, 3);
        #1 chk("bp_acc_ready0", acc_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold_lane0", lane(out_data, 0), 131071);
            chk("bp_hold_lane1", lane(out_data, 1), -131072);
            chk("bp_acc_ready", acc_ready, 0);
            chk("bp_grp_sel", grp_sel, 0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_acc_ready", acc_ready, 1);

        // Beat 2 (last of grp 0) accepted as beat 1 leaves
        tick();
        chk("b2_out_valid", out_valid, 1);
        chk("b2_lane0", lane(out_data, 0), 3959);
        chk("b2_lane1", lane(out_data, 1), -748);
        chk("b2_lane2", lane(out_data, 2), 7);
        chk("b2_grp_adv", grp_sel, 1);
        set_acc(10, 20, 30);
        start = 1'b1;

        // Beat 3 (grp 1), start during RUN ignored
        tick();
        start = 1'b0;
        chk("b3_lane0", lane(out_data, 0), -990);
        chk("b3_lane1", lane(out_data, 1), 520);
        chk("b3_lane2", lane(out_data, 2), 37);
        chk("b3_busy", busy, 1);
        chk("b3_grp_sel", grp_sel, 1);
        set_acc(-131000, 131000, -7);

        // Beat 4 (grp 1): saturation both ways
        tick();
        chk("b4_lane0_sat_lo", lane(out_data, 0), -131072);
        chk("b4_lane1_sat_hi", lane(out_data, 1), 131071);
        chk("b4_lane2", lane(out_data, 2), 0);
        set_acc(0, 0, 0);

        // Beat 5: last of pass, enter drain
        tick();
        chk("b5_lane0", lane(out_data, 0), -1000);
        chk("b5_lane1", lane(out_data, 1), 500);
        chk("b5_lane2", lane(out_data, 2), 7);
        out_ready = 1'b0;
        #1 chk("drain_acc_ready", acc_ready, 0);
        chk("drain_busy", busy, 1);
        chk("drain_done", done, 0);
        chk("drain_grp_sel", grp_sel, 1);

        tick();
        chk("drain_hold_valid", out_valid, 1);
        chk("drain_hold_done", done, 0);
        out_ready = 1'b1;

        tick();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_out_valid", out_valid, 0);
        chk("done_acc_ready", acc_ready, 0);

        tick();
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_acc_ready", acc_ready, 0);

        // Reset mid-pass during group 1 with a beat held
        start = 1'b1;
        tick();
        start = 1'b0;
        set_acc(1, 1, 1);
        for (int k = 0; k < 4; k++) tick();
        chk("mid_grp_sel", grp_sel, 1);
        chk("mid_out_valid", out_valid, 1);
        rst = 1'b1; acc_valid = 1'b0;
        tick();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", lane(out_data, 0), 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_grp_sel", grp_sel, 0);
        chk("midrst_done", done, 0);
        chk("midrst_acc_ready", acc_ready, 0);

        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_grp_sel", grp_sel, 0);
        acc_valid = 1'b1; set_acc(100, 200, -4);
        tick();
        chk("restart_lane0", lane(out_data, 0), 4058);
        chk("restart_lane1", lane(out_data, 1), -550);
        tick();
        chk("restart_pix1_grp", grp_sel, 0);
        tick();
        chk("restart_pix2_grp", grp_sel, 1);
        acc_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
